ba20x_lsu: RTL and testbench

//  Parametrised load/store unit; successor to the combinational memory formatter.

---
 rtl/ba20x_lsu.sv | 214 +++++++++++++++++++++
 tb/tb_ba20x_lsu.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ba20x_lsu.sv
`default_nettype none
// ============================================================================
// Module   : ba20x_lsu
// Purpose  : Load/store unit with valid/ready request handshake, registered
//            bus beats (grant/response) and per-byte-lane alignment.
//            Optional feature macro: LSU_MISALIGN_SPLIT_EN (two-beat split of
//            word-boundary-crossing accesses).
// Revision : 1.0 - initial release
// ============================================================================
module ba20x_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_i_valid,
  output logic              lsu_o_ready,
  input  logic [ADDR_W-1:0] lsu_i_addr,
  input  logic [XLEN-1:0]   lsu_i_data,
  input  logic              lsu_i_is_store,
  input  logic [4:0]        lsu_i_fmt_sel,
  output logic              lsu_o_valid,
  output logic [XLEN-1:0]   lsu_o_data,
  output logic              lsu_o_err,
  output logic              lsu_o_dreq,
  input  logic              lsu_i_dgnt,
  output logic [ADDR_W-1:0] lsu_o_daddr,
  output logic              lsu_o_dwe,
  output logic [XLEN/8-1:0] lsu_o_dmask,
  output logic [XLEN-1:0]   lsu_o_dwdata,
  input  logic              lsu_i_drvalid,
  input  logic [XLEN-1:0]   lsu_i_drdata
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ0 = 3'd1,
    S_RSP0 = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
    S_REQ1 = 3'd3,
    S_RSP1 = 3'd4,
`endif
    S_DONE = 3'd5
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_data, r_odata;
  logic              r_store, r_oerr;
  logic [4:0]        r_fmt;

  logic [3:0]        w_size;
  logic [LB-1:0]     w_off;
  logic [LB+2:0]     w_sh;
  logic [NB-1:0]     w_bmask, w_mask;
  logic [XLEN-1:0]   w_vmask, w_raw, w_load, w_wdata;
  logic [ADDR_W-1:0] w_base, w_addr;
  logic              w_legal, w_err, w_msb, w_rsp_done, w_dreq;

  assign w_off   = r_addr[LB-1:0];
  assign w_sh    = {w_off, 3'b000};
  assign w_base  = {r_addr[ADDR_W-1:LB], {LB{1'b0}}};
  assign w_legal = $onehot(r_fmt[3:0]) && !((XLEN == 32) && r_fmt[3]);

  always_comb begin
    w_size = 4'd0;
    w_msb  = w_raw[XLEN-1];
    if (r_fmt[0]) begin
      w_size = 4'd1;
      w_msb  = w_raw[7];
    end else if (r_fmt[1]) begin
      w_size = 4'd2;
      w_msb  = w_raw[15];
    end else if (r_fmt[2]) begin
      w_size = 4'd4;
      w_msb  = w_raw[31];
    end else if (r_fmt[3]) begin
      w_size = 4'd8;
    end
  end

  always_comb begin
    w_bmask = '0;
    w_vmask = '0;
    for (int i = 0; i < NB; i++) begin
      w_bmask[i]        = (i < int'(w_size));
      w_vmask[8*i +: 8] = {8{w_bmask[i]}};
    end
  end

  // Extracted lanes are right-aligned in w_raw; extend above the access size.
  assign w_load = (w_raw & w_vmask) | ((!r_fmt[4] && w_msb) ? ~w_vmask : '0);

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [XLEN-1:0]   r_rd0;
  logic [2*NB-1:0]   w_mask_wide;
  logic [2*XLEN-1:0] w_wr_wide, w_rd_wide;
  logic              w_split, w_beat1;

  assign w_err       = !w_legal;
  assign w_split     = (int'(w_off) + int'(w_size)) > NB;
  assign w_beat1     = (r_state == S_REQ1) || (r_state == S_RSP1);
  // Two-word view: low half is beat0, high half is beat1.
  assign w_mask_wide = {{NB{1'b0}}, w_bmask} << w_off;
  assign w_wr_wide   = {{XLEN{1'b0}}, r_data & w_vmask} << w_sh;
  assign w_mask      = w_beat1 ? w_mask_wide[2*NB-1:NB] : w_mask_wide[NB-1:0];
  assign w_wdata     = w_beat1 ? w_wr_wide[2*XLEN-1:XLEN] : w_wr_wide[XLEN-1:0];
  assign w_addr      = w_base + (w_beat1 ? ADDR_W'(NB) : '0);
  assign w_rd_wide   = (r_state == S_RSP1) ? {lsu_i_drdata, r_rd0}
                                           : {{XLEN{1'b0}}, lsu_i_drdata};
  assign w_raw       = XLEN'(w_rd_wide >> w_sh);
  assign w_rsp_done  = lsu_i_drvalid &&
                       (((r_state == S_RSP0) && !w_split) || (r_state == S_RSP1));
  assign w_dreq      = ((r_state == S_REQ0) && !w_err) || (r_state == S_REQ1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd0 <= '0;
    end else if ((r_state == S_RSP0) && lsu_i_drvalid) begin
      r_rd0 <= lsu_i_drdata;
    end
  end
`else
  logic [LB-1:0] w_amask;
  logic          w_misal;

  always_comb begin
    w_amask = '0;
    for (int j = 0; j < LB; j++) begin
      w_amask[j] = int'(w_size) > (1 << j);
    end
  end

  assign w_misal    = |(w_off & w_amask);
  assign w_err      = !w_legal || w_misal;
  assign w_mask     = w_bmask << w_off;
  assign w_wdata    = (r_data & w_vmask) << w_sh;
  assign w_addr     = w_base;
  assign w_raw      = lsu_i_drdata >> w_sh;
  assign w_rsp_done = lsu_i_drvalid && (r_state == S_RSP0);
  assign w_dreq     = (r_state == S_REQ0) && !w_err;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (lsu_i_valid) w_next = S_REQ0;
      // Decode faults are resolved here so no beat is ever requested.
      S_REQ0: begin
        if (w_err)           w_next = S_DONE;
        else if (lsu_i_dgnt) w_next = S_RSP0;
      end
      S_RSP0: begin
        if (lsu_i_drvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          w_next = w_split ? S_REQ1 : S_DONE;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_REQ1: if (lsu_i_dgnt)    w_next = S_RSP1;
      S_RSP1: if (lsu_i_drvalid) w_next = S_DONE;
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_store <= 1'b0;
      r_fmt   <= '0;
      r_odata <= '0;
      r_oerr  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && lsu_i_valid) begin
        r_addr  <= lsu_i_addr;
        r_data  <= lsu_i_data;
        r_store <= lsu_i_is_store;
        r_fmt   <= lsu_i_fmt_sel;
      end
      if ((r_state == S_REQ0) && w_err) begin
        r_odata <= '0;
        r_oerr  <= 1'b1;
      end else if (w_rsp_done) begin
        r_odata <= r_store ? '0 : w_load;
        r_oerr  <= 1'b0;
      end
    end
  end

  assign lsu_o_ready  = (r_state == S_IDLE);
  assign lsu_o_valid  = (r_state == S_DONE);
  assign lsu_o_data   = r_odata;
  assign lsu_o_err    = r_oerr;
  assign lsu_o_dreq   = w_dreq;
  assign lsu_o_daddr  = w_dreq ? w_addr : '0;
  assign lsu_o_dwe    = w_dreq && r_store;
  assign lsu_o_dmask  = w_dreq ? w_mask : '0;
  assign lsu_o_dwdata = w_dreq ? w_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ba20x_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ba20x_lsu
// Purpose  : Scoreboard-based self-checking bench for ba20x_lsu (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ba20x_lsu;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam logic [4:0] F_B  = 5'b00001, F_H = 5'b00010, F_W = 5'b00100;
  localparam logic [4:0] F_BU = 5'b10001, F_HU = 5'b10010;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_i_valid, lsu_o_ready, lsu_i_is_store;
  logic [31:0] lsu_i_addr, lsu_i_data, lsu_o_data;
  logic [4:0]  lsu_i_fmt_sel;
  logic        lsu_o_valid, lsu_o_err, lsu_o_dreq, lsu_i_dgnt, lsu_o_dwe, lsu_i_drvalid;
  logic [31:0] lsu_o_daddr, lsu_o_dwdata, lsu_i_drdata;
  logic [3:0]  lsu_o_dmask;

  always #5 clk = ~clk;

  ba20x_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .lsu_i_valid(lsu_i_valid), .lsu_o_ready(lsu_o_ready),
    .lsu_i_addr(lsu_i_addr), .lsu_i_data(lsu_i_data),
    .lsu_i_is_store(lsu_i_is_store), .lsu_i_fmt_sel(lsu_i_fmt_sel),
    .lsu_o_valid(lsu_o_valid), .lsu_o_data(lsu_o_data), .lsu_o_err(lsu_o_err),
    .lsu_o_dreq(lsu_o_dreq), .lsu_i_dgnt(lsu_i_dgnt), .lsu_o_daddr(lsu_o_daddr),
    .lsu_o_dwe(lsu_o_dwe), .lsu_o_dmask(lsu_o_dmask), .lsu_o_dwdata(lsu_o_dwdata),
    .lsu_i_drvalid(lsu_i_drvalid), .lsu_i_drdata(lsu_i_drdata)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  time  t_acc;

  // Present a request for one cycle; returns at the first falling edge after acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic st,
                       input logic [4:0] f, input logic [31:0] ed, input logic ee);
    @(negedge clk);
    lsu_i_valid = 1'b1; lsu_i_addr = a; lsu_i_data = d;
    lsu_i_is_store = st; lsu_i_fmt_sel = f;
    exp_q.push_back('{data: ed, err: ee});
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    lsu_i_valid = 1'b0;
  endtask

  // Memory side: grant after gd idle cycles, respond one cycle after grant.
  task automatic respond(input int gd, input logic [31:0] rd);
    repeat (gd) @(negedge clk);
    lsu_i_dgnt = 1'b1;
    @(negedge clk);
    lsu_i_dgnt = 1'b0; lsu_i_drvalid = 1'b1; lsu_i_drdata = rd;
    @(negedge clk);
    lsu_i_drvalid = 1'b0; lsu_i_drdata = '0;
  endtask

  task automatic wait_valid(output logic got, output int lat);
    for (int i = 0; i < 40 && lsu_o_valid !== 1'b1; i++) @(negedge clk);
    got = (lsu_o_valid === 1'b1);
    lat = int'(($time - t_acc + 5) / 10);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (lsu_o_ready !== 1'b1 || lsu_o_valid !== 1'b0 || lsu_o_err !== 1'b0 || lsu_o_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_core: ready=%b valid=%b err=%b data=%h, need 1 0 0 0", lsu_o_ready, lsu_o_valid, lsu_o_err, lsu_o_data);
    end
    checks++;
    if (lsu_o_dreq !== 1'b0 || lsu_o_dwe !== 1'b0 || lsu_o_dmask !== 4'h0 || lsu_o_daddr !== 32'h0 || lsu_o_dwdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: dreq=%b dwe=%b dmask=%b daddr=%h dwdata=%h, need all 0", lsu_o_dreq, lsu_o_dwe, lsu_o_dmask, lsu_o_daddr, lsu_o_dwdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    logic got; int lat; exp_t e;
    issue(32'h100, 32'h0, 1'b0, F_W, 32'hDEADBEEF, 1'b0);
    checks++;
    if (lsu_o_dreq !== 1'b1 || lsu_o_daddr !== 32'h100 || lsu_o_dmask !== 4'b1111 || lsu_o_dwe !== 1'b0 || lsu_o_ready !== 1'b0) begin
      failures++;
      $display("FAIL lw_beat: dreq=%b daddr=%h dmask=%b dwe=%b ready=%b, need 1 100 1111 0 0", lsu_o_dreq, lsu_o_daddr, lsu_o_dmask, lsu_o_dwe, lsu_o_ready);
    end
    respond(0, 32'hDEADBEEF);
    wait_valid(got, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || lat != 3) begin
      failures++;
      $display("FAIL lw_latency: valid=%b after %0d cycles, need 1 after 3", got, lat);
    end
    checks++;
    if (lsu_o_data !== e.data || lsu_o_err !== e.err) begin
      failures++;
      $display("FAIL lw_data: data=%h err=%b, need %h %b", lsu_o_data, lsu_o_err, e.data, e.err);
    end
    @(negedge clk);
    checks++;
    if (lsu_o_valid !== 1'b0 || lsu_o_ready !== 1'b1) begin
      failures++;
      $display("FAIL lw_pulse: valid=%b ready=%b one cycle later, need 0 1", lsu_o_valid, lsu_o_ready);
    end
  endtask

  task automatic test_byte_half_loads();
    logic got; int lat; exp_t e;
    logic [31:0] rd, ed; logic [7:0] b; logic [15:0] h; logic [3:0] em;
    logic [4:0] f;
    for (int k = 0; k < 10; k++) begin
      int o;
      if (k == 0) begin rd = 32'h80123456; o = 3; f = F_B; end
      else if (k == 1) begin rd = 32'h80123456; o = 3; f = F_BU; end
      else if (k < 6) begin rd = $urandom; o = k - 2; f = (k % 2) ? F_BU : F_B; end
      else begin rd = $urandom; o = (k % 2) * 2; f = (k < 8) ? F_H : F_HU; end
      if (f[0]) begin
        b  = rd[8*o +: 8];
        ed = f[4] ? {24'h0, b} : {{24{b[7]}}, b};
        em = 4'b0001 << o;
      end else begin
        h  = rd[8*o +: 16];
        ed = f[4] ? {16'h0, h} : {{16{h[15]}}, h};
        em = 4'b0011 << o;
      end
      issue(32'h400 + 32'(o), 32'h0, 1'b0, f, ed, 1'b0);
      checks++;
      if (lsu_o_dreq !== 1'b1 || lsu_o_dmask !== em || lsu_o_daddr !== 32'h400) begin
        failures++;
        $display("FAIL ld_beat[%0d]: dreq=%b dmask=%b daddr=%h, need 1 %b 400", k, lsu_o_dreq, lsu_o_dmask, lsu_o_daddr, em);
      end
      respond(0, rd);
      wait_valid(got, lat);
      e = exp_q.pop_front();
      checks++;
      if (!got || lsu_o_data !== e.data || lsu_o_err !== e.err) begin
        failures++;
        $display("FAIL ld_data[%0d]: valid=%b data=%h err=%b, need 1 %h %b", k, got, lsu_o_data, lsu_o_err, e.data, e.err);
      end
    end
  endtask

  task automatic test_store_half();
    logic got; int lat; exp_t e;
    issue(32'h102, 32'h1234ABCD, 1'b1, F_H, 32'h0, 1'b0);
    checks++;
    if (lsu_o_dreq !== 1'b1 || lsu_o_dwe !== 1'b1 || lsu_o_dmask !== 4'b1100 || lsu_o_dwdata !== 32'hABCD0000 || lsu_o_daddr !== 32'h100) begin
      failures++;
      $display("FAIL sh_beat: dreq=%b dwe=%b dmask=%b dwdata=%h daddr=%h, need 1 1 1100 abcd0000 100", lsu_o_dreq, lsu_o_dwe, lsu_o_dmask, lsu_o_dwdata, lsu_o_daddr);
    end
    respond(0, 32'hFFFFFFFF);
    wait_valid(got, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || lat != 3 || lsu_o_data !== e.data || lsu_o_err !== e.err) begin
      failures++;
      $display("FAIL sh_done: valid=%b lat=%0d data=%h err=%b, need 1 3 %h %b", got, lat, lsu_o_data, lsu_o_err, e.data, e.err);
    end
  endtask

  task automatic test_illegal_fmt();
    logic got; int lat; exp_t e;
    logic [4:0] fl [2];
    fl[0] = 5'b00110; fl[1] = 5'b01000;
    for (int k = 0; k < 2; k++) begin
      issue(32'h200, 32'h55, 1'b0, fl[k], 32'h0, 1'b1);
      checks++;
      if (lsu_o_dreq !== 1'b0) begin
        failures++;
        $display("FAIL fmt_nobeat[%0d]: dreq=%b, need 0", k, lsu_o_dreq);
      end
      wait_valid(got, lat);
      e = exp_q.pop_front();
      checks++;
      if (!got || lat != 2 || lsu_o_err !== e.err || lsu_o_data !== e.data) begin
        failures++;
        $display("FAIL fmt_err[%0d]: valid=%b lat=%0d err=%b data=%h, need 1 2 %b %h", k, got, lat, lsu_o_err, lsu_o_data, e.err, e.data);
      end
    end
  endtask

`ifdef LSU_MISALIGN_SPLIT_EN
  task automatic test_misaligned();
    logic got; int lat; exp_t e;
    issue(32'h1FE, 32'h0, 1'b0, F_W, 32'hDDCCBBAA, 1'b0);
    checks++;
    if (lsu_o_dreq !== 1'b1 || lsu_o_daddr !== 32'h1FC || lsu_o_dmask !== 4'b1100) begin
      failures++;
      $display("FAIL split_ld_b0: dreq=%b daddr=%h dmask=%b, need 1 1fc 1100", lsu_o_dreq, lsu_o_daddr, lsu_o_dmask);
    end
    respond(0, 32'hBBAA0000);
    checks++;
    if (lsu_o_dreq !== 1'b1 || lsu_o_daddr !== 32'h200 || lsu_o_dmask !== 4'b0011) begin
      failures++;
      $display("FAIL split_ld_b1: dreq=%b daddr=%h dmask=%b, need 1 200 0011", lsu_o_dreq, lsu_o_daddr, lsu_o_dmask);
    end
    respond(0, 32'h0000DDCC);
    wait_valid(got, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || lat != 5 || lsu_o_data !== e.data || lsu_o_err !== e.err) begin
      failures++;
      $display("FAIL split_ld_data: valid=%b lat=%0d data=%h err=%b, need 1 5 %h %b", got, lat, lsu_o_data, lsu_o_err, e.data, e.err);
    end
    issue(32'hFFFFFFFE, 32'h11223344, 1'b1, F_W, 32'h0, 1'b0);
    checks++;
    if (lsu_o_daddr !== 32'hFFFFFFFC || lsu_o_dmask !== 4'b1100 || lsu_o_dwdata !== 32'h33440000 || lsu_o_dwe !== 1'b1) begin
      failures++;
      $display("FAIL split_st_b0: daddr=%h dmask=%b dwdata=%h dwe=%b, need fffffffc 1100 33440000 1", lsu_o_daddr, lsu_o_dmask, lsu_o_dwdata, lsu_o_dwe);
    end
    respond(0, 32'h0);
    checks++;
    if (lsu_o_daddr !== 32'h0 || lsu_o_dmask !== 4'b0011 || lsu_o_dwdata !== 32'h00001122 || lsu_o_dreq !== 1'b1) begin
      failures++;
      $display("FAIL split_st_b1: dreq=%b daddr=%h dmask=%b dwdata=%h, need 1 0 0011 00001122", lsu_o_dreq, lsu_o_daddr, lsu_o_dmask, lsu_o_dwdata);
    end
    respond(0, 32'h0);
    wait_valid(got, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || lsu_o_data !== e.data || lsu_o_err !== e.err) begin
      failures++;
      $display("FAIL split_st_done: valid=%b data=%h err=%b, need 1 %h %b", got, lsu_o_data, lsu_o_err, e.data, e.err);
    end
  endtask
`else
  task automatic test_misaligned();
    logic got; int lat; exp_t e;
    logic [31:0] al [3]; logic [4:0] fm [3];
    al[0] = 32'h1FE; fm[0] = F_W;
    al[1] = 32'h101; fm[1] = F_H;
    al[2] = 32'h103; fm[2] = F_HU;
    for (int k = 0; k < 3; k++) begin
      issue(al[k], 32'h0, 1'b0, fm[k], 32'h0, 1'b1);
      checks++;
      if (lsu_o_dreq !== 1'b0) begin
        failures++;
        $display("FAIL misal_nobeat[%0d]: dreq=%b, need 0", k, lsu_o_dreq);
      end
      wait_valid(got, lat);
      e = exp_q.pop_front();
      checks++;
      if (!got || lat != 2 || lsu_o_err !== e.err || lsu_o_data !== e.data) begin
        failures++;
        $display("FAIL misal_err[%0d]: valid=%b lat=%0d err=%b data=%h, need 1 2 %b %h", k, got, lat, lsu_o_err, lsu_o_data, e.err, e.data);
      end
    end
  endtask
`endif

  task automatic test_gnt_stall();
    logic got; int lat; exp_t e; logic bad;
    bad = 1'b0;
    issue(32'h104, 32'hCAFEF00D, 1'b1, F_W, 32'h0, 1'b0);
    lsu_i_valid = 1'b1; lsu_i_addr = 32'h500; lsu_i_fmt_sel = F_B;
    for (int i = 0; i < 5; i++) begin
      if (lsu_o_dreq !== 1'b1 || lsu_o_daddr !== 32'h104 || lsu_o_dmask !== 4'b1111 ||
          lsu_o_dwdata !== 32'hCAFEF00D || lsu_o_dwe !== 1'b1 || lsu_o_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    lsu_i_valid = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stall_hold: dreq=%b daddr=%h dmask=%b dwdata=%h ready=%b, need 1 104 1111 cafef00d 0 throughout", lsu_o_dreq, lsu_o_daddr, lsu_o_dmask, lsu_o_dwdata, lsu_o_ready);
    end
    respond(0, 32'h0);
    wait_valid(got, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || lat != 8 || lsu_o_data !== e.data || lsu_o_err !== e.err) begin
      failures++;
      $display("FAIL stall_done: valid=%b lat=%0d data=%h err=%b, need 1 8 %h %b", got, lat, lsu_o_data, lsu_o_err, e.data, e.err);
    end
    @(negedge clk);
    checks++;
    if (lsu_o_valid !== 1'b0 || lsu_o_dreq !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_extra: valid=%b dreq=%b after completion, need 0 0", lsu_o_valid, lsu_o_dreq);
    end
  endtask

  task automatic test_back_to_back();
    logic got; int lat; exp_t e; logic seen;
    seen = 1'b0;
    lsu_i_drvalid = 1'b1; lsu_i_drdata = 32'h12345678;
    @(negedge clk);
    lsu_i_drvalid = 1'b0;
    repeat (2) begin
      if (lsu_o_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL idle_drvalid: valid=1 from stray response, need 0");
    end
    issue(32'h301, 32'h0, 1'b0, F_BU, 32'h000000AB, 1'b0);
    respond(0, 32'h0000AB00);
    wait_valid(got, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || lsu_o_data !== e.data || lsu_o_err !== e.err) begin
      failures++;
      $display("FAIL b2b_first: valid=%b data=%h err=%b, need 1 %h %b", got, lsu_o_data, lsu_o_err, e.data, e.err);
    end
    issue(32'h302, 32'h0, 1'b0, F_H, 32'hFFFF8000, 1'b0);
    respond(0, 32'h80000000);
    wait_valid(got, lat);
    e = exp_q.pop_front();
    checks++;
    if (!got || lat != 3 || lsu_o_data !== e.data || lsu_o_err !== e.err) begin
      failures++;
      $display("FAIL b2b_second: valid=%b lat=%0d data=%h err=%b, need 1 3 %h %b", got, lat, lsu_o_data, lsu_o_err, e.data, e.err);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    issue(32'h600, 32'h0, 1'b0, F_W, 32'h0, 1'b0);
    lsu_i_dgnt = 1'b1;
    @(negedge clk);
    lsu_i_dgnt = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (lsu_o_dreq !== 1'b0 || lsu_o_ready !== 1'b1 || lsu_o_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: dreq=%b ready=%b valid=%b, need 0 1 0", lsu_o_dreq, lsu_o_ready, lsu_o_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    lsu_i_drvalid = 1'b1; lsu_i_drdata = 32'hA5A5A5A5;
    @(negedge clk);
    lsu_i_drvalid = 1'b0;
    repeat (4) begin
      if (lsu_o_valid !== 1'b0 || lsu_o_dreq !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_late_rsp: valid or dreq seen after reset, need none");
    end
  endtask

  initial begin
    lsu_i_valid = 1'b0; lsu_i_addr = '0; lsu_i_data = '0; lsu_i_is_store = 1'b0;
    lsu_i_fmt_sel = '0; lsu_i_dgnt = 1'b0; lsu_i_drvalid = 1'b0; lsu_i_drdata = '0;
    test_reset();
    test_lw();
    test_byte_half_loads();
    test_store_half();
    test_illegal_fmt();
    test_misaligned();
    test_gnt_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, need completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
